// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter
// Round-robin arbiter feeding a single registered valid/ready output stage.
// Each cycle the stage can take a new entry, the first valid requester at or
// after the rotating pointer is granted and its payload and index are
// registered. The pointer then moves just past the winner, so a requester
// that keeps asking waits at most N_REQ-1 grants. A flush empties the stage
// and suppresses granting for that cycle.

module pipe_rr_arbiter #(
    parameter  int N_REQ     = 2,
    parameter  int DATA_SIZE = 32,
    localparam int IDX_W     = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ*DATA_SIZE-1:0] req_data_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [DATA_SIZE-1:0]       data_o,
    output logic [IDX_W-1:0]           id_o,
    output logic                       valid_o,
    input  logic                       ready_i
);

    // The rotation wraps explicitly, so non-power-of-two counts work, but
    // at least two requesters are needed for an index to exist.
    if (N_REQ < 2) begin : g_n_req_check
        $error("pipe_rr_arbiter: N_REQ must be at least 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 valid_q, valid_d;
    logic [DATA_SIZE-1:0] data_q,  data_d;
    logic [IDX_W-1:0]     id_q,    id_d;
    logic [IDX_W-1:0]     ptr_q,   ptr_d;   // highest-priority requester

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DATA_SIZE-1:0] payload [N_REQ];
    logic                 accept;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     ptr_after_grant;

    // Split the flat payload bus into one word per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_payload
        assign payload[g] = req_data_i[g*DATA_SIZE +: DATA_SIZE];
    end

    // The stage can take a new entry when it is empty or being drained
    // this cycle; reset and flush both block any grant.
    assign accept = !rst && !flush && (!valid_q || ready_i);

    // Scan requesters starting at the pointer, wrapping at N_REQ-1, and
    // pick the first one asserting valid.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output of a combinational block is given a default
        // first, so no path through it leaves a value unassigned (latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Pointer value that follows a grant: one past the winner, wrapping.
    always_comb begin
        if (grant_idx == IDX_W'(N_REQ - 1)) begin
            ptr_after_grant = '0;
        end else begin
            ptr_after_grant = grant_idx + IDX_W'(1);
        end
    end

    // One-hot ready back to the winning requester when the stage accepts.
    always_comb begin
        req_ready_o = '0;
        if (accept && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Next state of the output stage and the round-robin pointer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (grant_found) begin
                valid_d = 1'b1;
                data_d  = payload[grant_idx];
                id_d    = grant_idx;
                ptr_d   = ptr_after_grant;
            end else begin
                // Held entry drained (or stage already empty), nothing new.
                valid_d = 1'b0;
            end
        end else if (flush) begin
            // Flush drops the held entry; payload and index are left as is.
            valid_d = 1'b0;
        end
        // Otherwise stalled: everything holds.
    end

    // Register the output stage and pointer; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // flops update together from values sampled before the edge.
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload register is reset too, because data_o is
            // defined as zero after reset rather than left undefined.
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;

    // At most one requester is ever told it was accepted.
    a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready_o))
        else $error("pipe_rr_arbiter: more than one req_ready_o bit set");

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter with three requesters.
// Inputs change on the falling edge; the combinational ready is checked
// 1ns later and the registered outputs on the following falling edge.
// The reference model picks the valid requester with the smallest
// circular distance from the pointer.

module tb_pipe_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            ready_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   data_o;
    logic [IW-1:0]   id_o;
    logic            valid_o;

    logic [DW-1:0]   pay [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_id    = 0;
    int            m_ptr   = 0;

    always #5 clk = ~clk;

    always_comb req_data_i = {pay[2], pay[1], pay[0]};

    pipe_rr_arbiter #(
        .N_REQ     (N),
        .DATA_SIZE (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .data_o      (data_o),
        .id_o        (id_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    // Valid requester closest (circularly) at or after the pointer, or -1.
    function automatic int winner();
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req_valid_i[i]) begin
                int d;
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int w;
        if (rst || flush || (m_valid && !ready_i)) return '0;
        w = winner();
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        int w;
        @(posedge clk);
        w = winner();
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (!m_valid || ready_i) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = pay[w];
                m_id    = w;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ready_i = 1'b1; req_valid_i = '1;
        pay[0] = 32'hA0; pay[1] = 32'hB1; pay[2] = 32'hC2;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (req_ready_o !== '0) begin
                n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready_o);
            end
            step();
        end
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o);
        end
        n_checks++;
        if (data_o !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", data_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 3'b001) begin
            n_fail++; $display("FAIL reset_first_ready: got %b expected 001", req_ready_o);
        end
        step();
        n_checks++;
        if (valid_o !== 1'b1 || id_o !== 2'd0 || data_o !== 32'hA0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got v=%b id=%0d d=%h expected v=1 id=0 d=a0",
                     valid_o, id_o, data_o);
        end
    endtask

    task automatic test_rotation();
        int            exp_id [4] = '{0, 1, 2, 0};
        logic [DW-1:0] exp_d  [4] = '{32'hA0, 32'hB1, 32'hC2, 32'hA0};
        rst = 1'b1; step(); rst = 1'b0;
        req_valid_i = '1; ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (valid_o !== 1'b1 || id_o !== IW'(exp_id[c]) || data_o !== exp_d[c]) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                         c, valid_o, id_o, data_o, exp_id[c], exp_d[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        // Pointer is 1 after the rotation ended on requester 0.
        step();
        n_checks++;
        if (id_o !== 2'd1 || data_o !== 32'hB1) begin
            n_fail++; $display("FAIL bp_load: got id=%0d d=%h expected id=1 d=b1", id_o, data_o);
        end
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready_o !== '0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 000", c, req_ready_o);
            end
            step();
            n_checks++;
            if (valid_o !== 1'b1 || id_o !== 2'd1 || data_o !== 32'hB1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h expected v=1 id=1 d=b1",
                         c, valid_o, id_o, data_o);
            end
        end
        ready_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 3'b100) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 100", req_ready_o);
        end
        step();
        n_checks++;
        if (valid_o !== 1'b1 || id_o !== 2'd2 || data_o !== 32'hC2) begin
            n_fail++;
            $display("FAIL bp_no_bubble: got v=%b id=%0d d=%h expected v=1 id=2 d=c2",
                     valid_o, id_o, data_o);
        end
    endtask

    task automatic test_skip_idle();
        int exp_id [2] = '{2, 0};
        rst = 1'b1; step(); rst = 1'b0;
        ready_i = 1'b1; req_valid_i = 3'b001;
        step();                                  // grant 0, pointer -> 1
        #1;
        n_checks++;
        if (req_ready_o !== 3'b001) begin
            n_fail++; $display("FAIL skip_ready: got %b expected 001", req_ready_o);
        end
        step();
        n_checks++;
        if (valid_o !== 1'b1 || id_o !== 2'd0) begin
            n_fail++; $display("FAIL skip_grant0: got v=%b id=%0d expected v=1 id=0", valid_o, id_o);
        end
        req_valid_i = 3'b101;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (id_o !== IW'(exp_id[c])) begin
                n_fail++; $display("FAIL skip_order[%0d]: got id=%0d expected %0d", c, id_o, exp_id[c]);
            end
        end
    endtask

    task automatic test_flush();
        // Pointer is 1 after the skip test ended on requester 0.
        req_valid_i = '1; ready_i = 1'b1;
        step();                                  // grant 1, pointer -> 2
        ready_i = 1'b0; flush = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== '0) begin
            n_fail++; $display("FAIL flush_ready: got %b expected 000", req_ready_o);
        end
        step();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: got %b expected 0", valid_o);
        end
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 3'b100) begin
            n_fail++; $display("FAIL flush_resume_ready: got %b expected 100", req_ready_o);
        end
        step();
        n_checks++;
        if (valid_o !== 1'b1 || id_o !== 2'd2) begin
            n_fail++; $display("FAIL flush_resume: got v=%b id=%0d expected v=1 id=2", valid_o, id_o);
        end
    endtask

    task automatic test_reset_midstream();
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1; step(); rst = 1'b0;
            req_valid_i = '1; ready_i = 1'b0;
            step(); step();                      // grant 0 then stall? no: stage empty
            // Stage held id 0 since ready_i=0; drain once to reach pointer 2.
            ready_i = 1'b1;
            step();                              // grant 1, pointer -> 2
            n_checks++;
            if (valid_o !== 1'b1 || id_o !== 2'd1) begin
                n_fail++; $display("FAIL mid_setup[%0d]: got v=%b id=%0d expected v=1 id=1",
                                   pass, valid_o, id_o);
            end
            rst = 1'b1; flush = (pass == 1);
            step();
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_fail++; $display("FAIL mid_valid[%0d]: got %b expected 0", pass, valid_o);
            end
            rst = 1'b0; flush = 1'b0;
            #1;
            n_checks++;
            if (req_ready_o !== 3'b001) begin
                n_fail++; $display("FAIL mid_ptr[%0d]: got %b expected 001", pass, req_ready_o);
            end
            step();
            n_checks++;
            if (id_o !== 2'd0 || valid_o !== 1'b1) begin
                n_fail++; $display("FAIL mid_first[%0d]: got v=%b id=%0d expected v=1 id=0",
                                   pass, valid_o, id_o);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid_i = N'($urandom);
            ready_i     = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) pay[i] = $urandom;
            end
            #1;
            n_checks++;
            if (req_ready_o !== exp_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready_o, exp_ready());
            end
            step();
            n_checks++;
            if (valid_o !== m_valid || id_o !== IW'(m_id) || data_o !== m_data) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b id=%0d d=%h expected v=%b id=%0d d=%h",
                         c, valid_o, id_o, data_o, m_valid, m_id, m_data);
            end
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ready_i = 1'b1; req_valid_i = '0;
        for (int i = 0; i < N; i++) pay[i] = '0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_skip_idle();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
